message_serializer: RTL and testbench
=====================================

# message_serializer

Downstream stage of `decodeMessage`. Accepts one 192-bit recovered text line (24 ASCII characters, leftmost character in bits [191:184]) through a valid/ready handshake and emits it one 8-bit character per accepted beat on a second valid/ready stream. Feeds the character sink (UART TX / display driver) and counts completed lines.

## Interface
- `CHARS`, 24: characters per line; line width is 8*CHARS.
- `CNT_W`, 8: width of the completed-line counter.

Ports:
- `clk`  in  1  single clock; all state is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `msg_valid`  in  1  upstream line available.
- `msg_data`  in  8*CHARS  decoded line; char 0 = bits [8*CHARS-1 -: 8].
- `msg_ready`  out  1  block can accept a line.
- `char_valid`  out  1  `char_data` is valid.
- `char_data`  out  8  current character.
- `char_last`  out  1  current character is the final one emitted for this line.
- `char_ready`  in  1  sink accepts the character.
- `busy`  out  1  a line is held (state SEND).
- `line_count`  out  CNT_W  number of lines fully emitted since reset.

## Operation
- FSM states: IDLE, SEND.
- IDLE: `msg_ready`=1. On `msg_valid && msg_ready`, register `msg_data` into the line register, set index to 0 and go to SEND.
- SEND: `msg_ready`=0, `busy`=1, `char_valid`=1, `char_data` = line register byte at index.
- Beat: `char_valid && char_ready` advances the index by 1. The beat with `char_last`=1 returns the FSM to IDLE and increments `line_count`.
- `char_last` = (index == CHARS-1) without the macro.
- Characters are emitted in order char 0 .. char CHARS-1. Values are passed unmodified; no ASCII checking.
- `line_count` wraps from 2^CNT_W-1 to 0.
- Stall: while `char_valid && !char_ready`, `char_data`, `char_last` and index hold stable.
- `msg_data` changing during SEND has no effect. Only the registered copy is used.

## Timing
- Reset (async assert, sync release): FSM=IDLE, index=0, line register=0. `msg_ready`=1, `char_valid`=0, `char_data`=8'h00, `char_last`=0, `busy`=0, `line_count`=0.
- Load latency: the first character is valid in the cycle after the load handshake.
- Throughput: 1 character/cycle with `char_ready` held high. A full line takes CHARS cycles plus 1 IDLE cycle before the next load, so back-to-back lines take CHARS+1 cycles each.
- `line_count` updates on the clock edge of the last beat and is visible the next cycle, together with `msg_ready`=1.
- Reset asserted mid-line: the partial line is discarded and no `char_last` is issued. Outputs take their reset values immediately.
- `msg_valid` asserted in SEND is ignored until IDLE. Upstream must hold `msg_valid` and `msg_data` until `msg_ready`.

## Configuration
- Macro: `MESSAGE_SERIALIZER_SKIP_NUL_EN`.
- Defined:
  - Bytes equal to 8'h00 are never emitted. On load, the block computes the index of the first and last non-NUL characters; interior NULs are skipped by advancing to the next non-NUL index, adding no bubble cycles.
  - `char_last` marks the last non-NUL character.
  - An all-NUL line emits no beats: the FSM returns to IDLE on the next cycle and `line_count` still increments.
- Undefined: every byte, including 8'h00, is emitted and exactly CHARS beats occur per line.

## Test plan
- Reset, then load "ABCDEFGHIJKLMNOPQRSTUVWX" (0x41..0x58) with `char_ready`=1:
  - chars 0x41..0x58 on 24 consecutive cycles starting 1 cycle after load;
  - `char_last` only on 0x58;
  - `line_count`=1, and `msg_ready`=1 the cycle after.
- Same line with `char_ready` toggling 1,0,1,0…: each char is held through its stall cycles; 24 beats in order; no duplicates or drops.
- Two lines with `msg_valid` held high: the second load occurs exactly 25 cycles after the first; `line_count`=2.
- Deassert `rst_n` after the 10th beat (0x4A): outputs are at reset values immediately, no `char_last` occurs, `line_count`=0; the next line is emitted from char 0.
- 256 lines with CNT_W=8: `line_count` reads 0 after the 256th line.
- With `MESSAGE_SERIALIZER_SKIP_NUL_EN`:
  - "HI" followed by 22 bytes of 8'h00 emits 0x48, 0x49, with `char_last` on 0x49;
  - an all-zero line emits no beats and increments `line_count`;
  - "A\0B" plus zeros emits 0x41, 0x42 on consecutive cycles.

Source files
------------

// File: rtl/message_serializer.sv
// Serializes one CHARS-byte text line into a valid/ready byte stream and counts completed lines.
// Optional MESSAGE_SERIALIZER_SKIP_NUL_EN drops 8'h00 bytes without adding bubble cycles.
module message_serializer #(
    parameter int CHARS = 24,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               msg_valid,
    input  logic [8*CHARS-1:0] msg_data,
    output logic               msg_ready,
    output logic               char_valid,
    output logic [7:0]         char_data,
    output logic               char_last,
    input  logic               char_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   line_count
);
    localparam int IW = (CHARS > 1) ? $clog2(CHARS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(CHARS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q, state_d;
    logic [CHARS-1:0][7:0] line_q, msg_bytes;
    logic [IW-1:0]         idx_q, idx_nxt, idx_load;
    logic [CNT_W-1:0]      cnt_q;
    logic                  load, beat, done;
    logic [7:0]            cur;

    // char 0 sits in the most significant byte, so element CHARS-1 holds it
    assign msg_bytes  = msg_data;
    assign cur        = line_q[LAST_IDX - idx_q];
    assign line_count = cnt_q;

`ifdef MESSAGE_SERIALIZER_SKIP_NUL_EN
    logic [IW-1:0] last_q, last_load;
    logic          empty_q, empty_load;

    always_comb begin
        idx_load   = '0;
        last_load  = '0;
        empty_load = 1'b1;
        for (int i = CHARS - 1; i >= 0; i--) begin
            if (msg_bytes[CHARS-1-i] != 8'h00) begin
                idx_load   = IW'(i);
                empty_load = 1'b0;
            end
        end
        for (int i = 0; i < CHARS; i++) begin
            if (msg_bytes[CHARS-1-i] != 8'h00) last_load = IW'(i);
        end
    end

    // jump straight to the next non-NUL character so interior NULs cost no cycles
    always_comb begin
        idx_nxt = idx_q;
        for (int i = CHARS - 1; i >= 0; i--) begin
            if (IW'(i) > idx_q && line_q[CHARS-1-i] != 8'h00) idx_nxt = IW'(i);
        end
    end
`else
    assign idx_load = '0;
    assign idx_nxt  = idx_q + IW'(1);
`endif

    always_comb begin
        state_d    = state_q;
        msg_ready  = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        char_last  = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                busy      = 1'b1;
                char_data = cur;
`ifdef MESSAGE_SERIALIZER_SKIP_NUL_EN
                char_valid = !empty_q;
                char_last  = !empty_q && (idx_q == last_q);
                if (empty_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
`else
                char_valid = 1'b1;
                char_last  = (idx_q == LAST_IDX);
`endif
                if (char_valid && char_ready && char_last) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        beat = char_valid && char_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
`ifdef MESSAGE_SERIALIZER_SKIP_NUL_EN
            last_q  <= '0;
            empty_q <= 1'b0;
`endif
        end else begin
            if (load) begin
                line_q  <= msg_bytes;
                idx_q   <= idx_load;
`ifdef MESSAGE_SERIALIZER_SKIP_NUL_EN
                last_q  <= last_load;
                empty_q <= empty_load;
`endif
            end else if (beat && !char_last) begin
                idx_q <= idx_nxt;
            end
            if (done) cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_message_serializer.sv
// Bench for message_serializer: queue-based line model checked every cycle, plus directed literal checks.
module tb_message_serializer;
    localparam int CHARS = 24;
    localparam int LW    = 8 * CHARS;

    logic          clk, rst_n, msg_valid, msg_ready, char_valid, char_last, char_ready, busy;
    logic [LW-1:0] msg_data;
    logic [7:0]    char_data, line_count;

    message_serializer #(.CHARS(CHARS), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_data(msg_data),
        .msg_ready(msg_ready), .char_valid(char_valid), .char_data(char_data),
        .char_last(char_last), .char_ready(char_ready), .busy(busy), .line_count(line_count)
    );

    typedef struct { logic [7:0] ch; logic last; } ent_t;

    ent_t q[$];
    ent_t log[$];
    int   beat_cyc[$];
    int   loads[$];
    logic pend_empty = 1'b0;
    logic [7:0] m_cnt = 8'h00;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic m_busy();
        return (q.size() > 0) || pend_empty;
    endfunction

    function automatic void push_line(input logic [LW-1:0] d);
        ent_t e;
        for (int i = 0; i < CHARS; i++) begin
            e.ch   = d[LW-1-8*i -: 8];
            e.last = 1'b0;
`ifdef MESSAGE_SERIALIZER_SKIP_NUL_EN
            if (e.ch != 8'h00) q.push_back(e);
`else
            q.push_back(e);
`endif
        end
        if (q.size() > 0) q[q.size()-1].last = 1'b1;
        else              pend_empty = 1'b1;
    endfunction

    // Model: one pending-character queue per line; a line ends when its last entry is accepted.
    initial forever begin
        ent_t e;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            pend_empty = 1'b0;
            m_cnt      = 8'h00;
        end else begin
            cyc++;
            if (char_valid && char_ready) begin
                e.ch = char_data; e.last = char_last;
                log.push_back(e);
                beat_cyc.push_back(cyc);
            end
            if (msg_valid && msg_ready) loads.push_back(cyc);
            if (pend_empty) begin
                pend_empty = 1'b0;
                m_cnt++;
            end else if (q.size() > 0) begin
                if (char_ready) begin
                    e = q.pop_front();
                    if (e.last) m_cnt++;
                end
            end else if (msg_valid) begin
                push_line(msg_data);
            end
        end
    end

    initial forever begin
        logic [19:0] exp;
        @(negedge clk);
        if (q.size() > 0) exp = {1'b0, 1'b1, q[0].ch, q[0].last, 1'b1, m_cnt};
        else              exp = {!m_busy(), 1'b0, 8'h00, 1'b0, m_busy(), m_cnt};
        check("cycle_outputs", {12'h0, msg_ready, char_valid, char_data, char_last, busy, line_count},
              {12'h0, exp});
    end

    function automatic logic [LW-1:0] alpha();
        logic [LW-1:0] d;
        for (int i = 0; i < CHARS; i++) d[LW-1-8*i -: 8] = 8'h41 + 8'(i);
        return d;
    endfunction

    task automatic clear_logs();
        log.delete(); beat_cyc.delete(); loads.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input bit toggle);
        for (int n = 0; n < 400 && m_busy(); n++) begin
            @(negedge clk);
            char_ready = toggle ? !char_ready : 1'b1;
        end
        char_ready = 1'b1;
        check("idle_timeout", {31'h0, m_busy()}, 32'h0);
    endtask

    task automatic send_line(input logic [LW-1:0] d, input bit toggle);
        int n0;
        n0 = loads.size();
        @(negedge clk);
        msg_valid = 1'b1; msg_data = d; char_ready = 1'b1;
        for (int n = 0; n < 100 && loads.size() == n0; n++) @(negedge clk);
        check("load_timeout", loads.size(), n0 + 1);
        msg_valid = 1'b0;
        msg_data  = {6{$urandom}};
        wait_idle(toggle);
    endtask

    function automatic int order_errs(input int lines);
        int bad = 0;
        for (int i = 0; i < log.size(); i++) begin
            if (log[i].ch != 8'h41 + 8'(i % CHARS)) bad++;
            if (log[i].last != ((i % CHARS) == CHARS - 1)) bad++;
        end
        if (log.size() != lines * CHARS) bad++;
        return bad;
    endfunction

    function automatic int count_lasts();
        int c = 0;
        foreach (log[i]) if (log[i].last) c++;
        return c;
    endfunction

    initial begin
        logic [LW-1:0] d;
        rst_n = 1'b1; msg_valid = 1'b0; msg_data = '0; char_ready = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        check("reset_outputs", {12'h0, msg_ready, char_valid, char_data, char_last, busy, line_count},
              32'h80000);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();

        // one line at full rate
        send_line(alpha(), 1'b0);
        check("t1_order", order_errs(1), 0);
        if (log.size() == CHARS) begin
            check("t1_first_char", log[0].ch, 32'h41);
            check("t1_last_char", {23'h0, log[23].last, log[23].ch}, 32'h158);
            check("t1_latency", beat_cyc[0] - loads[0], 1);
            check("t1_span", beat_cyc[23] - beat_cyc[0], 23);
        end
        check("t1_line_count", line_count, 1);
        check("t1_msg_ready", msg_ready, 1);

        // alternating char_ready stalls
        do_reset();
        send_line(alpha(), 1'b1);
        check("t2_order", order_errs(1), 0);
        check("t2_line_count", line_count, 1);

        // back-to-back lines with msg_valid held
        do_reset();
        @(negedge clk);
        msg_valid = 1'b1; msg_data = alpha();
        for (int n = 0; n < 100 && loads.size() < 2; n++) @(negedge clk);
        msg_valid = 1'b0;
        wait_idle(1'b0);
        check("t3_loads", loads.size(), 2);
        if (loads.size() >= 2) check("t3_load_gap", loads[1] - loads[0], 25);
        check("t3_line_count", line_count, 2);
        check("t3_order", order_errs(2), 0);

        // reset mid-line after the 10th beat
        do_reset();
        @(negedge clk);
        msg_valid = 1'b1; msg_data = alpha();
        for (int n = 0; n < 100 && loads.size() < 1; n++) @(negedge clk);
        msg_valid = 1'b0;
        for (int n = 0; n < 100 && log.size() < 10; n++) @(negedge clk);
        check("t4_beats", log.size(), 10);
        if (log.size() >= 10) check("t4_tenth", log[9].ch, 32'h4A);
        #1 rst_n = 1'b0;
        #1 check("t4_reset_outputs",
                 {12'h0, msg_ready, char_valid, char_data, char_last, busy, line_count}, 32'h80000);
        check("t4_no_last", count_lasts(), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        send_line(alpha(), 1'b0);
        check("t4_restart_order", order_errs(1), 0);
        check("t4_line_count", line_count, 1);

        // counter wrap after 256 lines
        do_reset();
        @(negedge clk);
        msg_valid = 1'b1; msg_data = alpha();
        for (int n = 0; n < 7000 && loads.size() < 256; n++) @(negedge clk);
        msg_valid = 1'b0;
        wait_idle(1'b0);
        check("t5_lines", count_lasts(), 256);
        check("t5_wrap", line_count, 0);

`ifdef MESSAGE_SERIALIZER_SKIP_NUL_EN
        do_reset();
        d = '0; d[LW-1 -: 8] = 8'h48; d[LW-9 -: 8] = 8'h49;
        send_line(d, 1'b0);
        check("s1_beats", log.size(), 2);
        if (log.size() == 2) begin
            check("s1_first", {23'h0, log[0].last, log[0].ch}, 32'h048);
            check("s1_second", {23'h0, log[1].last, log[1].ch}, 32'h149);
        end

        do_reset();
        send_line('0, 1'b0);
        check("s2_no_beats", log.size(), 0);
        check("s2_line_count", line_count, 1);

        do_reset();
        d = '0; d[LW-1 -: 8] = 8'h41; d[LW-17 -: 8] = 8'h42;
        send_line(d, 1'b0);
        check("s3_beats", log.size(), 2);
        if (log.size() == 2) begin
            check("s3_chars", {log[0].ch, log[1].ch}, 32'h4142);
            check("s3_consecutive", beat_cyc[1] - beat_cyc[0], 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
